// File: rtl/line_window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : line_window_3x3
// Description : Streaming 3x3 neighbourhood generator for 24-bit RGB video.
//               Accepts one raster-order pixel per valid cycle, keeps the two
//               previous lines in line buffers and emits the full 3x3 window
//               for every pixel with x>=2 and y>=2. No backpressure, no frame
//               store; pure data movement.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous, active-high
//               pix_valid  - pix_data carries a new pixel this cycle
//               pix_sof    - with pix_valid: pixel is (0,0) of a new frame
//               pix_data   - input pixel {R,G,B}
//               win_valid  - win_data holds a new window this cycle
//               win_data   - element k=3*r+c at [PIX_W*k +: PIX_W],
//                            r=0 top row, c=0 left column
//               frame_done - one-cycle pulse with the last window of a frame
//               win_x/win_y- (LINE_WINDOW_COORD_EN only) window centre coords
// Config      : `define LINE_WINDOW_COORD_EN to add the win_x/win_y outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module line_window_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  input  logic [PIX_W-1:0]       pix_data,
  output logic                   win_valid,
  output logic [9*PIX_W-1:0]     win_data,
  output logic                   frame_done
`ifdef LINE_WINDOW_COORD_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y
`endif
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [XW-1:0] C_X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] C_Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] C_X_TWO  = XW'(2);
  localparam logic [YW-1:0] C_Y_TWO  = YW'(2);
  localparam logic [XW-1:0] C_X_ONE  = XW'(1);
  localparam logic [YW-1:0] C_Y_ONE  = YW'(1);

  // Line buffers: lb1 holds line y-1, lb2 holds line y-2. Not reset.
  logic [PIX_W-1:0] lb1_mem [IMG_WIDTH];
  logic [PIX_W-1:0] lb2_mem [IMG_WIDTH];

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;

  // Two left-hand window columns; the right-hand column comes straight from
  // the current taps, so only columns 0 and 1 need storage. [row][col].
  logic [2:0][1:0][PIX_W-1:0] sh_q, sh_d;

  logic                 win_valid_q, win_valid_d;
  logic [9*PIX_W-1:0]   win_data_q, win_data_d;
  logic                 frame_done_q, frame_done_d;
  logic [XW-1:0]        win_x_q, win_x_d;
  logic [YW-1:0]        win_y_q, win_y_d;

  logic [XW-1:0]        cur_x;
  logic [YW-1:0]        cur_y;
  logic [PIX_W-1:0]     lb1_rd;
  logic [PIX_W-1:0]     lb2_rd;
  logic [2:0][PIX_W-1:0] tap;

  always_comb begin
    // sof forces the pixel to (0,0) regardless of where the counters were.
    cur_x  = pix_sof ? '0 : col_q;
    cur_y  = pix_sof ? '0 : row_q;
    // Asynchronous read returns the old contents; the write below lands on
    // the clock edge, giving read-before-write behaviour.
    lb1_rd = lb1_mem[cur_x];
    lb2_rd = lb2_mem[cur_x];
    tap[0] = lb2_rd;
    tap[1] = lb1_rd;
    tap[2] = pix_data;

    col_d        = col_q;
    row_d        = row_q;
    sh_d         = sh_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_data_d   = win_data_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;

    if (pix_valid) begin
      if (cur_x == C_X_LAST) begin
        col_d = '0;
        row_d = (cur_y == C_Y_LAST) ? '0 : cur_y + C_Y_ONE;
      end else begin
        col_d = cur_x + C_X_ONE;
        row_d = cur_y;
      end

      for (int r = 0; r < 3; r++) begin
        sh_d[r][0] = sh_q[r][1];
        sh_d[r][1] = tap[r];
      end

      if (cur_x >= C_X_TWO && cur_y >= C_Y_TWO) begin
        win_valid_d = 1'b1;
        for (int r = 0; r < 3; r++) begin
          win_data_d[PIX_W*(3*r+0) +: PIX_W] = sh_q[r][0];
          win_data_d[PIX_W*(3*r+1) +: PIX_W] = sh_q[r][1];
          win_data_d[PIX_W*(3*r+2) +: PIX_W] = tap[r];
        end
        win_x_d = cur_x - C_X_ONE;
        win_y_d = cur_y - C_Y_ONE;
      end

      frame_done_d = (cur_x == C_X_LAST) && (cur_y == C_Y_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      sh_q         <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      frame_done_q <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sh_q         <= sh_d;
      win_valid_q  <= win_valid_d;
      win_data_q   <= win_data_d;
      frame_done_q <= frame_done_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
    end
  end

  // Line RAM write: current pixel into lb1, displaced lb1 entry into lb2.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_mem[cur_x] <= pix_data;
      lb2_mem[cur_x] <= lb1_rd;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign frame_done = frame_done_q;

`ifdef LINE_WINDOW_COORD_EN
  assign win_x = win_x_q;
  assign win_y = win_y_q;
`else
  // Coordinates are tracked but unused when the ports are absent.
  logic unused_coord;
  assign unused_coord = ^{win_x_q, win_y_q};
`endif

endmodule
`default_nettype wire
